// File: rtl/reg_xfer_pkg.sv
// ---------------------------------------------------------------------------
// reg_xfer_pkg
// Shared types and constants for the register-bus transfer master.
//   xfer_state_t : transfer FSM state encoding (IDLE, WAIT, RESP)
//   wait_load()  : turns the LATENCY parameter into the wait-counter load value
// ---------------------------------------------------------------------------
package reg_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } xfer_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_LATENCY   = 15;
    localparam int WAIT_CNT_W    = 4;

    // Latency values above the counter range are clamped rather than wrapped,
    // so a mis-set parameter never produces a shorter wait than intended.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int latency);
        logic [WAIT_CNT_W-1:0] val_s;
        if (latency > MAX_LATENCY) begin
            val_s = 4'd15;
        end else begin
            val_s = latency[WAIT_CNT_W-1:0];
        end
        return val_s;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that increments on 'inc' and sticks at all-ones.
//   clk   : clock, rising edge
//   rst   : asynchronous, active-high reset (count -> 0)
//   inc   : increment request for this cycle
//   count : current count value (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_C  = {W{1'b1}};
    localparam logic [W-1:0] ONE_C  = W'(1'b1);
    localparam logic [W-1:0] ZERO_C = {W{1'b0}};

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;

    // Next count: increment unless already saturated
    always_comb begin
        count_next_s = count_r;
        if (inc && (count_r != MAX_C)) begin
            count_next_s = count_r + ONE_C;
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= ZERO_C;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/reg_xfer_master.sv
// ---------------------------------------------------------------------------
// reg_xfer_master
// Write-then-readback initiator for the register bus. A request value is
// driven onto reg_data_in, the responder output is sampled LATENCY+1 edges
// later, and written value, read value and compare flag are returned on a
// valid/ready response handshake. Saturating counters track completed
// transfers and mismatches.
//   clk, rst                         : clock (rising) / async active-high reset
//   req_valid, req_ready, req_data   : request handshake and write value
//   rsp_valid, rsp_ready             : response handshake
//   rsp_wdata, rsp_rdata, rsp_match  : written value, sampled value, equality
//   reg_data_in                      : drive toward the responder
//   reg_data_out                     : responder's registered output
//   xfer_count, mismatch_count       : saturating transfer / mismatch counts
// ---------------------------------------------------------------------------
module reg_xfer_master
    import reg_xfer_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_wdata,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_match,
    output logic [WIDTH-1:0] reg_data_in,
    input  logic [WIDTH-1:0] reg_data_out,
    output logic [CNT_W-1:0] xfer_count,
    output logic [CNT_W-1:0] mismatch_count
);

    localparam logic [WAIT_CNT_W-1:0] LAT_C       = wait_load(LATENCY);
    localparam logic [WAIT_CNT_W-1:0] WAIT_ZERO_C = {WAIT_CNT_W{1'b0}};
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE_C  = WAIT_CNT_W'(1'b1);
    localparam logic [WIDTH-1:0]      DATA_ZERO_C = {WIDTH{1'b0}};

    xfer_state_t           state_r;
    xfer_state_t           state_next_s;
    logic [WAIT_CNT_W-1:0] wait_cnt_r;
    logic [WIDTH-1:0]      reg_data_in_r;
    logic [WIDTH-1:0]      rsp_wdata_r;
    logic [WIDTH-1:0]      rsp_rdata_r;
    logic                  rsp_match_r;
    logic                  rsp_valid_r;
    logic                  accept_s;
    logic                  sample_s;
    logic                  done_s;
    logic                  mismatch_inc_s;

    // Gated by rst so no request is taken while reset is held
    assign req_ready = (state_r == IDLE) && !rst;

    // FSM next-state and transfer event decode
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        sample_s     = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept_s     = 1'b1;
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == WAIT_ZERO_C) begin
                    sample_s     = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    done_s       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: write value capture, wait countdown, readback sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r    <= WAIT_ZERO_C;
            reg_data_in_r <= DATA_ZERO_C;
            rsp_wdata_r   <= DATA_ZERO_C;
            rsp_rdata_r   <= DATA_ZERO_C;
            rsp_match_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                reg_data_in_r <= req_data;
                rsp_wdata_r   <= req_data;
                wait_cnt_r    <= LAT_C;
            end else if ((state_r == WAIT) && !sample_s) begin
                wait_cnt_r <= wait_cnt_r - WAIT_ONE_C;
            end
            // Compare against the held write value, not req_data, which the
            // requester may already have changed for the next transfer.
            if (sample_s) begin
                rsp_rdata_r <= reg_data_out;
                rsp_match_r <= (reg_data_out == rsp_wdata_r);
                rsp_valid_r <= 1'b1;
            end else if (done_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign mismatch_inc_s = done_s && !rsp_match_r;

    sat_counter #(.W(CNT_W)) u_xfer_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (done_s),
        .count (xfer_count)
    );

    sat_counter #(.W(CNT_W)) u_mismatch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mismatch_inc_s),
        .count (mismatch_count)
    );

    assign reg_data_in = reg_data_in_r;
    assign rsp_wdata   = rsp_wdata_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_match   = rsp_match_r;
    assign rsp_valid   = rsp_valid_r;

endmodule

// File: tb/tb_reg_xfer_master.sv
// ---------------------------------------------------------------------------
// tb_reg_xfer_master
// Bench for reg_xfer_master. Instance u_dut (LATENCY=1, 16-bit counters)
// talks to a registered responder with 25ns output delay that can invert
// its data; instance u_dut2 (LATENCY=0, 2-bit counters) talks to a
// combinational loopback responder.
// ---------------------------------------------------------------------------
module tb_reg_xfer_master;

    localparam int W   = 8;
    localparam int LAT = 1;
    localparam int CW  = 16;
    localparam int CW2 = 2;

    typedef struct packed {
        logic [W-1:0] w;
        logic [W-1:0] r;
        logic         m;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_match;
    logic [W-1:0]  req_data, rsp_wdata, rsp_rdata, reg_data_in;
    logic [W-1:0]  reg_data_out = 8'h00;
    logic [CW-1:0] xfer_count, mismatch_count;

    logic           req_valid2, req_ready2, rsp_valid2, rsp_ready2, rsp_match2;
    logic [W-1:0]   req_data2, rsp_wdata2, rsp_rdata2, reg_data_in2, reg_data_out2;
    logic [CW2-1:0] xfer_count2, mismatch_count2;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic inv    = 1'b0;

    exp_t exp_q[$];
    exp_t exp2_q[$];
    exp_t e;
    exp_t e2;
    int   acc_hist[$];
    int   last_acc  = 0;
    int   last_acc2 = 0;
    logic prev_v    = 1'b0;
    logic prev_v2   = 1'b0;

    logic [W-1:0] vals2 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    reg_xfer_master #(.WIDTH(W), .LATENCY(LAT), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_wdata(rsp_wdata), .rsp_rdata(rsp_rdata), .rsp_match(rsp_match),
        .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
        .xfer_count(xfer_count), .mismatch_count(mismatch_count)
    );

    reg_xfer_master #(.WIDTH(W), .LATENCY(0), .CNT_W(CW2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_data(req_data2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_wdata(rsp_wdata2), .rsp_rdata(rsp_rdata2), .rsp_match(rsp_match2),
        .reg_data_in(reg_data_in2), .reg_data_out(reg_data_out2),
        .xfer_count(xfer_count2), .mismatch_count(mismatch_count2)
    );

    // 60ns period leaves margin over the responder's 25ns output delay
    always #30 clk = ~clk;

    // Edge counter used to time accepts and response launches
    always @(posedge clk) cyc <= cyc + 1;

    // Registered responder: captures reg_data_in, output appears 25ns later
    always @(posedge clk) reg_data_out <= #25 (inv ? ~reg_data_in : reg_data_in);

    // Combinational loopback responder for the LATENCY=0 instance
    assign reg_data_out2 = reg_data_in2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor: records accepts, checks response launch timing, scoreboards responses
    always @(negedge clk) begin
        if (req_valid && req_ready) begin
            last_acc <= cyc + 1;
            acc_hist.push_back(cyc + 1);
        end
        if (rsp_valid && !prev_v) chk("rsp_valid_rise_edge", cyc, last_acc + LAT + 1);
        prev_v <= rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_wdata", rsp_wdata, e.w);
                chk("rsp_rdata", rsp_rdata, e.r);
                chk("rsp_match", rsp_match, e.m);
            end
        end

        if (req_valid2 && req_ready2) last_acc2 <= cyc + 1;
        if (rsp_valid2 && !prev_v2) chk("rsp_valid2_rise_edge", cyc, last_acc2 + 1);
        prev_v2 <= rsp_valid2;
        if (rsp_valid2 && rsp_ready2) begin
            if (exp2_q.size() == 0) begin
                chk("unexpected_response2", 32'd1, 32'd0);
            end else begin
                e2 = exp2_q.pop_front();
                chk("rsp_wdata2", rsp_wdata2, e2.w);
                chk("rsp_rdata2", rsp_rdata2, e2.r);
                chk("rsp_match2", rsp_match2, e2.m);
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [W-1:0] r, input logic m, input bit push);
        bit got;
        got = 1'b0;
        if (push) exp_q.push_back('{d, r, m});
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_data  = d;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        chk("req_accepted", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("reg_data_in_after_accept", reg_data_in, d);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic drain2();
        for (int i = 0; i < 100 && exp2_q.size() != 0; i++) @(negedge clk);
        chk("drain2", exp2_q.size(), 32'd0);
        @(negedge clk);
    endtask

    // Global time limit so the run can never hang
    initial begin
        #(60 * 20000);
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        bit got;
        req_valid  = 1'b1;
        req_data   = 8'h55;
        rsp_ready  = 1'b1;
        req_valid2 = 1'b0;
        req_data2  = 8'h00;
        rsp_ready2 = 1'b1;

        // Reset held for three cycles with a request pending
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_reg_data_in", reg_data_in, 32'd0);
        chk("rst_rsp_wdata", rsp_wdata, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_match", rsp_match, 32'd0);
        chk("rst_xfer_count", xfer_count, 32'd0);
        chk("rst_mismatch_count", mismatch_count, 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 32'd1);
        chk("post_rst_req_ready2", req_ready2, 32'd1);

        // Single transfer
        send(8'hA5, 8'hA5, 1'b1, 1'b1);
        drain();
        chk("single_reg_data_in_held", reg_data_in, 32'hA5);
        chk("single_xfer_count", xfer_count, 32'd1);
        chk("single_mismatch_count", mismatch_count, 32'd0);

        // Back-to-back: req_valid held, data advanced after each accept
        acc_hist.delete();
        exp_q.push_back('{8'h01, 8'h01, 1'b1});
        exp_q.push_back('{8'h02, 8'h02, 1'b1});
        exp_q.push_back('{8'h03, 8'h03, 1'b1});
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_data  = 8'h01;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (req_ready) got = 1'b1;
            end
            chk("b2b_accepted", {31'd0, got}, 32'd1);
            @(posedge clk); #1;
            if (k == 0) req_data = 8'h02;
            else if (k == 1) req_data = 8'h03;
            else req_valid = 1'b0;
        end
        drain();
        chk("b2b_accept_count", acc_hist.size(), 32'd3);
        if (acc_hist.size() == 3) begin
            chk("b2b_spacing_1", acc_hist[1] - acc_hist[0], 32'd4);
            chk("b2b_spacing_2", acc_hist[2] - acc_hist[1], 32'd4);
        end
        chk("b2b_xfer_count", xfer_count, 32'd4);
        chk("b2b_reg_data_in_held", reg_data_in, 32'h03);

        // Response backpressure for 10 cycles
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(8'h3C, 8'h3C, 1'b1, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        chk("bp_rsp_valid_seen", {31'd0, got}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 32'd1);
            chk("bp_rsp_wdata", rsp_wdata, 32'h3C);
            chk("bp_rsp_rdata", rsp_rdata, 32'h3C);
            chk("bp_req_ready", req_ready, 32'd0);
            chk("bp_xfer_count", xfer_count, 32'd4);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain();
        chk("bp_xfer_count_after", xfer_count, 32'd5);
        chk("bp_mismatch_count_after", mismatch_count, 32'd0);

        // Mismatch: responder inverts data
        @(posedge clk); #1;
        inv = 1'b1;
        send(8'hF0, 8'h0F, 1'b0, 1'b1);
        drain();
        @(posedge clk); #1;
        inv = 1'b0;
        @(negedge clk);
        chk("mm_mismatch_count", mismatch_count, 32'd1);
        chk("mm_xfer_count", xfer_count, 32'd6);

        // Reset while the transfer is waiting for its sample edge
        send(8'h99, 8'h00, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_rsp_valid", rsp_valid, 32'd0);
            chk("midrst_req_ready", req_ready, 32'd0);
            chk("midrst_reg_data_in", reg_data_in, 32'd0);
            chk("midrst_xfer_count", xfer_count, 32'd0);
            chk("midrst_mismatch_count", mismatch_count, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_rsp", rsp_valid, 32'd0);
        end
        chk("midrst_req_ready_after", req_ready, 32'd1);
        chk("midrst_xfer_count_after", xfer_count, 32'd0);

        // Saturation on the 2-bit-counter, LATENCY=0 instance
        for (int k = 0; k < 5; k++) begin
            exp2_q.push_back('{vals2[k], vals2[k], 1'b1});
            @(posedge clk); #1;
            req_valid2 = 1'b1;
            req_data2  = vals2[k];
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (req_ready2) got = 1'b1;
            end
            chk("sat_accepted", {31'd0, got}, 32'd1);
            @(posedge clk); #1;
            req_valid2 = 1'b0;
            if (k == 2) begin
                drain2();
                chk("sat_xfer_count_3", xfer_count2, 32'd3);
            end
        end
        drain2();
        chk("sat_xfer_count_5", xfer_count2, 32'd3);
        chk("sat_mismatch_count", mismatch_count2, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
